// File: rtl/vec_store_seq.sv
// ----------------------------------------------------------------------------
// vec_store_seq
//
// Vector store sequencer. A start pulse in IDLE captures five vector lanes and
// a word-aligned base address. The lanes are then written to data memory as
// consecutive word stores over a valid/ready write port. busy stalls the
// control path while a store is in flight. done pulses for one cycle at the end.
//
// Optional feature (compile-time macro VSTORE_MASK_EN):
//   Adds the lane_mask input. Lanes with a 0 mask bit are skipped in zero
//   cycles. Each written lane keeps its own address slot.
//   An all-zero mask goes straight to DONE.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   start      in   1      store request, sampled only in IDLE
//   base_addr  in   AW     byte address of lane 0 (bits [1:0] ignored)
//   lane_0..4  in   WIDTH  lane data, captured at the accepted start
//   lane_mask  in   5      per-lane write enable (VSTORE_MASK_EN only)
//   mem_we     out  1      write request (valid)
//   mem_addr   out  AW     word-aligned write address
//   mem_wdata  out  WIDTH  write data
//   mem_ready  in   1      memory accepts the write when mem_we is 1
//   busy       out  1      sequence in flight
//   done       out  1      one-cycle completion pulse
// ----------------------------------------------------------------------------
module vec_store_seq #(
    parameter int WIDTH = 32,
    parameter int AW    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [WIDTH-1:0] lane_0,
    input  logic [WIDTH-1:0] lane_1,
    input  logic [WIDTH-1:0] lane_2,
    input  logic [WIDTH-1:0] lane_3,
    input  logic [WIDTH-1:0] lane_4,
`ifdef VSTORE_MASK_EN
    input  logic [4:0]       lane_mask,
`endif
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [2:0]       idx_r;
    logic [2:0]       idx_nx_s;
    logic [4:0]       mask_r;
    logic [4:0]       mask_in_s;
    logic [AW-1:0]    base_r;
    logic [AW-1:0]    base_in_s;
    logic [AW-1:0]    addr_r;
    logic [WIDTH-1:0] wdata_r;
    logic [WIDTH-1:0] lane_r    [5];
    logic [WIDTH-1:0] lane_in_s [5];
    logic             load_s;
    logic             adv_s;
    logic [3:0]       first_s;
    logic [3:0]       next_s;

    // Lowest enabled lane at or above start_idx; bit 3 flags that one exists.
    function automatic logic [3:0] next_lane(input logic [4:0] mask,
                                             input logic [2:0] start_idx);
        logic [3:0] res;
        res = 4'd0;
        // Descending scan so the lowest qualifying index is the one kept.
        for (int i = 4; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= start_idx)) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

    // Gather input lanes, aligned base address and the effective mask.
    always_comb begin
        lane_in_s[0] = lane_0;
        lane_in_s[1] = lane_1;
        lane_in_s[2] = lane_2;
        lane_in_s[3] = lane_3;
        lane_in_s[4] = lane_4;
        base_in_s    = base_addr & {{(AW-2){1'b1}}, 2'b00};
`ifdef VSTORE_MASK_EN
        mask_in_s    = lane_mask;
`else
        mask_in_s    = 5'b11111;
`endif
    end

    // Next-state logic and datapath load/advance strobes.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        load_s     = 1'b0;
        adv_s      = 1'b0;
        first_s    = next_lane(mask_in_s, 3'd0);
        // idx_r never exceeds 4, so idx_r + 1 (at most 5) cannot wrap.
        next_s     = next_lane(mask_r, idx_r + 3'd1);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s   = 1'b1;
                    idx_nx_s = first_s[2:0];
                    if (first_s[3]) begin
                        state_nx_s = ST_WRITE;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (mem_ready) begin
                    if (next_s[3]) begin
                        adv_s    = 1'b1;
                        idx_nx_s = next_s[2:0];
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end else begin
                    state_nx_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and index register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            idx_r   <= 3'd0;
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
        end
    end

    // Captured operands plus registered address/data. Nothing here depends
    // combinationally on mem_ready at the outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_r  <= {AW{1'b0}};
            mask_r  <= 5'd0;
            addr_r  <= {AW{1'b0}};
            wdata_r <= {WIDTH{1'b0}};
            for (int i = 0; i < 5; i++) begin
                lane_r[i] <= {WIDTH{1'b0}};
            end
        end else if (load_s) begin
            base_r  <= base_in_s;
            mask_r  <= mask_in_s;
            addr_r  <= base_in_s + (AW'(first_s[2:0]) << 2'd2);
            wdata_r <= lane_in_s[first_s[2:0]];
            for (int i = 0; i < 5; i++) begin
                lane_r[i] <= lane_in_s[i];
            end
        end else if (adv_s) begin
            // The address follows the lane index, so skipped lanes leave gaps.
            addr_r  <= base_r + (AW'(next_s[2:0]) << 2'd2);
            wdata_r <= lane_r[next_s[2:0]];
        end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    assign mem_we    = (state_r == ST_WRITE);
    assign busy      = (state_r != ST_IDLE);
    assign done      = (state_r == ST_DONE);
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_vec_store_seq.sv
`timescale 1ns/1ps
module tb_vec_store_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mem_ready = 1'b1;
    logic [31:0] base_addr = 32'd0;
    logic [31:0] lane_0 = 32'd0;
    logic [31:0] lane_1 = 32'd0;
    logic [31:0] lane_2 = 32'd0;
    logic [31:0] lane_3 = 32'd0;
    logic [31:0] lane_4 = 32'd0;
`ifdef VSTORE_MASK_EN
    logic [4:0]  lane_mask = 5'h1f;
`endif
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;

    vec_store_seq #(.WIDTH(32), .AW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .lane_0    (lane_0),
        .lane_1    (lane_1),
        .lane_2    (lane_2),
        .lane_3    (lane_3),
        .lane_4    (lane_4),
`ifdef VSTORE_MASK_EN
        .lane_mask (lane_mask),
`endif
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Model state: expected write sequence and timing of the current store.
    bit          active = 1'b0;
    int          n_base = 0;
    int          exp_done_rel = 0;
    int          done_cnt = 0;
    int          done_rel_seen = -1;
    int          hold_cnt = 0;
    logic [31:0] hold_addr = 32'hFFFF_FFFF;
    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic [31:0] lanes_v [5];
    int          cmp_rel;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model while a store is being tracked.
    always @(negedge clk) begin
        if (active && reset) begin
            cmp_rel = cyc - n_base;
            chk("busy", busy, (cmp_rel >= 1 && cmp_rel <= exp_done_rel));
            chk("mem_we", mem_we, (cmp_rel >= 1 && cmp_rel < exp_done_rel));
            chk("done", done, (cmp_rel == exp_done_rel));
            if (done) begin
                done_cnt++;
                done_rel_seen = cmp_rel;
            end
            if (mem_we) begin
                if (exp_addr_q.size() == 0) begin
                    chk("write_unexpected", 1'b1, 1'b0);
                end else begin
                    chk("mem_addr", mem_addr, exp_addr_q[0]);
                    chk("mem_wdata", mem_wdata, exp_data_q[0]);
                    if (mem_addr == hold_addr) hold_cnt++;
                    if (mem_ready) begin
                        log_addr.push_back(mem_addr);
                        log_data.push_back(mem_wdata);
                        void'(exp_addr_q.pop_front());
                        void'(exp_data_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic set_lanes(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                             input logic [31:0] d, input logic [31:0] e);
        lanes_v[0] = a; lanes_v[1] = b; lanes_v[2] = c; lanes_v[3] = d; lanes_v[4] = e;
    endtask

    // Build the expected writes from the lanes/mask, then issue start.
    task automatic begin_store(input logic [31:0] base, input logic [4:0] mask, input int stall_n);
        int nl;
        nl = 0;
        exp_addr_q.delete(); exp_data_q.delete();
        log_addr.delete(); log_data.delete();
        for (int i = 0; i < 5; i++) begin
            if (mask[i]) begin
                exp_addr_q.push_back((base & 32'hFFFF_FFFC) + 32'(4 * i));
                exp_data_q.push_back(lanes_v[i]);
                nl++;
            end
        end
        exp_done_rel  = nl + stall_n + 1;
        done_cnt      = 0;
        done_rel_seen = -1;
        hold_cnt      = 0;
        lane_0 = lanes_v[0]; lane_1 = lanes_v[1]; lane_2 = lanes_v[2];
        lane_3 = lanes_v[3]; lane_4 = lanes_v[4];
        base_addr = base;
`ifdef VSTORE_MASK_EN
        lane_mask = mask;
`endif
        mem_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        n_base = cyc - 1;
        active = 1'b1;
    endtask

    task automatic run_store(input logic [31:0] base, input logic [4:0] mask,
                             input int stall_lane, input int stall_n, input bit inject);
        int p;
        int eff;
        int rel;
        int guard;
        p = 0;
        eff = 0;
        if (stall_lane >= 0 && mask[stall_lane]) begin
            eff = stall_n;
            for (int i = 0; i < stall_lane; i++) if (mask[i]) p++;
        end
        begin_store(base, mask, eff);
        rel = 1;
        guard = 0;
        while (rel <= exp_done_rel + 1 && guard < 60) begin
            mem_ready = !(eff > 0 && rel >= 1 + p && rel <= p + eff);
            if (inject) begin
                lane_0 = 32'hDEAD_0000; lane_1 = 32'hDEAD_0001; lane_2 = 32'hDEAD_0002;
                lane_3 = 32'hDEAD_0003; lane_4 = 32'hDEAD_0004;
                base_addr = ~base;
                start = (rel == 2 || rel == exp_done_rel);
            end
            @(posedge clk); #1;
            rel = cyc - n_base;
            guard++;
        end
        start = 1'b0;
        mem_ready = 1'b1;
        active = 1'b0;
        chk("done_count", done_cnt, 1);
        chk("lanes_left", exp_addr_q.size(), 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic store
        set_lanes(32'h11, 32'h22, 32'h33, 32'h44, 32'h55);
        run_store(32'h100, 5'h1f, -1, 0, 1'b0);
        chk("basic_done_cycle", done_rel_seen, 6);
        chk("basic_nwrites", log_addr.size(), 5);
        chk("basic_addr0", log_addr[0], 32'h100);
        chk("basic_data0", log_data[0], 32'h11);
        chk("basic_addr3", log_addr[3], 32'h10C);
        chk("basic_addr4", log_addr[4], 32'h110);
        chk("basic_data4", log_data[4], 32'h55);

        // Backpressure: mem_ready low 3 cycles on lane 2
        hold_addr = 32'h108;
        run_store(32'h100, 5'h1f, 2, 3, 1'b0);
        chk("bp_done_cycle", done_rel_seen, 9);
        chk("bp_hold_cycles", hold_cnt, 4);
        chk("bp_nwrites", log_addr.size(), 5);
        chk("bp_data2", log_data[2], 32'h33);
        chk("bp_data3", log_data[3], 32'h44);
        hold_addr = 32'hFFFF_FFFF;

        // Alignment and wrap
        set_lanes(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
        run_store(32'hFFFF_FFF7, 5'h1f, -1, 0, 1'b0);
        chk("wrap_addr0", log_addr[0], 32'hFFFF_FFF4);
        chk("wrap_addr1", log_addr[1], 32'hFFFF_FFF8);
        chk("wrap_addr2", log_addr[2], 32'hFFFF_FFFC);
        chk("wrap_addr3", log_addr[3], 32'h0000_0000);
        chk("wrap_addr4", log_addr[4], 32'h0000_0004);

        // Start while busy: new lanes and starts ignored
        set_lanes(32'h1234_0000, 32'h1234_1111, 32'h1234_2222, 32'h1234_3333, 32'h1234_4444);
        run_store(32'h400, 5'h1f, -1, 0, 1'b1);
        chk("sb_done_cycle", done_rel_seen, 6);
        chk("sb_data0", log_data[0], 32'h1234_0000);
        chk("sb_data4", log_data[4], 32'h1234_4444);
        chk("sb_addr4", log_addr[4], 32'h410);
        @(posedge clk); #1;
        chk("sb_idle_after", busy, 1'b0);

        // Async reset during lane 3
        set_lanes(32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
        begin_store(32'h300, 5'h1f, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        active = 1'b0;
        chk("ar_pre_addr", mem_addr, 32'h30C);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_mem_we", mem_we, 1'b0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_done", done, 1'b0);
        chk("ar_addr", mem_addr, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("ar_idle_busy", busy, 1'b0);
        chk("ar_idle_we", mem_we, 1'b0);
        chk("ar_nwrites", log_addr.size(), 3);
        set_lanes(32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4);
        run_store(32'h300, 5'h1f, -1, 0, 1'b0);
        chk("ar_restart_addr0", log_addr[0], 32'h300);
        chk("ar_restart_data0", log_data[0], 32'hC0);
        chk("ar_restart_done", done_rel_seen, 6);

`ifdef VSTORE_MASK_EN
        // Sparse mask
        set_lanes(32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hD4);
        run_store(32'h200, 5'b10101, -1, 0, 1'b0);
        chk("mask_done_cycle", done_rel_seen, 4);
        chk("mask_nwrites", log_addr.size(), 3);
        chk("mask_addr0", log_addr[0], 32'h200);
        chk("mask_addr1", log_addr[1], 32'h208);
        chk("mask_addr2", log_addr[2], 32'h210);
        chk("mask_data1", log_data[1], 32'hD2);

        // Empty mask
        run_store(32'h200, 5'b00000, -1, 0, 1'b0);
        chk("mask0_done_cycle", done_rel_seen, 1);
        chk("mask0_nwrites", log_addr.size(), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
